// File: rtl/mem_bridge.sv
// mem_bridge: connects a CPU core to a slow external memory.
// Each core access is latched, held on the external bus until the memory
// acknowledges it or a wait-cycle limit expires, and then the core gets a
// one-cycle 'locked' step pulse. Read data reaches the core via core_in.
//
// Optional feature: define MEM_BRIDGE_LASTHIT_EN to add a one-entry
// last-read cache. When the core re-reads the address it read last, the
// access completes in two cycles and the external memory is not used.
// Any write empties the cache.

module mem_bridge #(
  parameter int          TIMEOUT = 255,
  parameter logic [7:0]  FILL    = 8'hFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] core_address,
  input  logic [7:0]  core_out,
  input  logic        core_we,
  output logic [7:0]  core_in,
  output logic        locked,
  output logic        ext_req,
  output logic [19:0] ext_addr,
  output logic [7:0]  ext_wdata,
  output logic        ext_we,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata,
  output logic        timeout_err
);

  // Counter value seen on the last WAIT cycle before the access is abandoned.
  localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [7:0]  counter;
  logic [7:0]  counter_d;
  logic        ext_req_d;
  logic [19:0] ext_addr_d;
  logic [7:0]  ext_wdata_d;
  logic        ext_we_d;
  logic [7:0]  core_in_d;
  logic        locked_d;
  logic        timeout_err_d;
  logic        wait_expired;
  logic        hit;

  assign wait_expired = (counter == COUNT_LAST);

`ifdef MEM_BRIDGE_LASTHIT_EN
  logic        valid;
  logic        valid_d;
  logic [19:0] tag;
  logic [19:0] tag_d;

  assign hit = !core_we && valid && (core_address == tag);
`else
  assign hit = 1'b0;
`endif

  // State register; reset drops any outstanding access back to IDLE.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; acknowledge takes priority over the wait-cycle limit.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ext_ack || wait_expired) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Next values of every registered output; everything holds unless changed.
  always_comb begin
    counter_d     = counter;
    ext_req_d     = ext_req;
    ext_addr_d    = ext_addr;
    ext_wdata_d   = ext_wdata;
    ext_we_d      = ext_we;
    core_in_d     = core_in;
    locked_d      = 1'b0;
    timeout_err_d = timeout_err;
`ifdef MEM_BRIDGE_LASTHIT_EN
    valid_d       = valid;
    tag_d         = tag;
`endif
    case (state)
      ST_IDLE: begin
        ext_addr_d  = core_address;
        ext_we_d    = core_we;
        ext_wdata_d = core_out;
        counter_d   = 8'd0;
        if (hit) begin
          ext_req_d = 1'b0;
          locked_d  = 1'b1;
        end else begin
          ext_req_d = 1'b1;
        end
`ifdef MEM_BRIDGE_LASTHIT_EN
        if (core_we) begin
          valid_d = 1'b0;
        end
`endif
      end
      ST_WAIT: begin
        if (ext_ack) begin
          ext_req_d = 1'b0;
          locked_d  = 1'b1;
          if (!ext_we) begin
            core_in_d = ext_rdata;
`ifdef MEM_BRIDGE_LASTHIT_EN
            tag_d     = ext_addr;
            valid_d   = 1'b1;
`endif
          end
        end else if (wait_expired) begin
          ext_req_d     = 1'b0;
          locked_d      = 1'b1;
          timeout_err_d = 1'b1;
          if (!ext_we) begin
            core_in_d = FILL;
`ifdef MEM_BRIDGE_LASTHIT_EN
            tag_d     = ext_addr;
            valid_d   = 1'b1;
`endif
          end
        end else begin
          counter_d = counter + 8'd1;
        end
      end
      ST_DONE: begin
        locked_d = 1'b0;
      end
      default: begin
        ext_req_d = 1'b0;
      end
    endcase
  end

  // Output and datapath registers, all cleared by reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      counter     <= 8'd0;
      ext_req     <= 1'b0;
      ext_addr    <= 20'd0;
      ext_wdata   <= 8'd0;
      ext_we      <= 1'b0;
      core_in     <= 8'd0;
      locked      <= 1'b0;
      timeout_err <= 1'b0;
`ifdef MEM_BRIDGE_LASTHIT_EN
      valid       <= 1'b0;
      tag         <= 20'd0;
`endif
    end else begin
      counter     <= counter_d;
      ext_req     <= ext_req_d;
      ext_addr    <= ext_addr_d;
      ext_wdata   <= ext_wdata_d;
      ext_we      <= ext_we_d;
      core_in     <= core_in_d;
      locked      <= locked_d;
      timeout_err <= timeout_err_d;
`ifdef MEM_BRIDGE_LASTHIT_EN
      valid       <= valid_d;
      tag         <= tag_d;
`endif
    end
  end

endmodule
